// File: rtl/reduce_pipeline.sv
// rtl/reduce_pipeline.sv - pipelined multi-channel OR/AND/XOR/NOR bit reduction
// FANIN-ary registered tree with valid/ready flow control and a sticky accumulator.
module reduce_pipeline #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int FANIN    = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_reduced,
  output logic [1:0]                out_op,
  output logic                      out_any,
  input  logic                      acc_clear,
  output logic [CHANNELS-1:0]       out_sticky
);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef logic [CHANNELS-1:0][WIDTH-1:0] bus_t;

  // Number of live operand bits entering stage s.
  function automatic int stage_width(input int s);
    int n;
    n = WIDTH;
    for (int i = 0; i < s; i++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  function automatic int calc_lat();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 1) begin
        n = (n + FANIN - 1) / FANIN;
        l++;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  localparam int LAT = calc_lat();

  // One tree level: node k combines bits [k*FANIN +: FANIN]; missing bits of a
  // short final group are the op's identity because acc starts at that value.
  function automatic bus_t reduce_stage(input bus_t src, input logic [1:0] op,
                                        input int nin, input logic last);
    bus_t r;
    logic acc;
    int   nout;
    r    = '0;
    nout = (nin + FANIN - 1) / FANIN;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (k < nout) begin
          acc = (op == OP_AND);
          for (int j = 0; j < FANIN; j++) begin
            if (k * FANIN + j < nin) begin
              case (op)
                OP_AND:  acc = acc & src[c][k*FANIN+j];
                OP_XOR:  acc = acc ^ src[c][k*FANIN+j];
                default: acc = acc | src[c][k*FANIN+j];
              endcase
            end
          end
          r[c][k] = acc;
        end
      end
      if (last && op == OP_NOR) r[c][0] = ~r[c][0];
    end
    return r;
  endfunction

  bus_t                data_q    [LAT];
  bus_t                data_d    [LAT];
  bus_t                src_data  [LAT];
  logic                valid_q   [LAT];
  logic                src_valid [LAT];
  logic [1:0]          op_q      [LAT];
  logic [1:0]          src_op    [LAT];
  logic [CHANNELS-1:0] final_d;
  logic                any_q;
  logic                any_d;
  logic                advance;
  logic                handshake;
  logic [CHANNELS-1:0] sticky_q;
  logic [CHANNELS-1:0] sticky_d;

  assign advance   = !valid_q[LAT-1] || out_ready;
  assign in_ready  = advance;
  assign handshake = valid_q[LAT-1] && out_ready;

  always_comb begin
    src_data[0]  = in_data;
    src_valid[0] = in_valid;
    src_op[0]    = in_op;
    for (int s = 1; s < LAT; s++) begin
      src_data[s]  = data_q[s-1];
      src_valid[s] = valid_q[s-1];
      src_op[s]    = op_q[s-1];
    end
    for (int s = 0; s < LAT; s++) begin
      data_d[s] = reduce_stage(src_data[s], src_op[s], stage_width(s), s == LAT - 1);
    end
    final_d = '0;
    for (int c = 0; c < CHANNELS; c++) final_d[c] = data_d[LAT-1][c][0];
    any_d = |final_d;
  end

  // Bubbles shift through with valid=0 exactly like beats.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < LAT; s++) begin
        valid_q[s] <= 1'b0;
        op_q[s]    <= 2'b00;
        data_q[s]  <= '0;
      end
      any_q <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < LAT; s++) begin
        valid_q[s] <= src_valid[s];
        op_q[s]    <= src_op[s];
        data_q[s]  <= data_d[s];
      end
      any_q <= any_d;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (acc_clear && handshake) sticky_d = out_reduced;
    else if (acc_clear)         sticky_d = '0;
    else if (handshake)         sticky_d = sticky_q | out_reduced;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sticky_q <= '0;
    else          sticky_q <= sticky_d;
  end

  always_comb begin
    out_reduced = '0;
    for (int c = 0; c < CHANNELS; c++) out_reduced[c] = data_q[LAT-1][c][0];
  end

  assign out_valid  = valid_q[LAT-1];
  assign out_op     = op_q[LAT-1];
  assign out_any    = any_q;
  assign out_sticky = sticky_q;

endmodule

// File: doc/reduce_pipeline.md
Name: reduce_pipeline

Overview:
Parametrised, pipelined multi-channel bit-reduction unit. It generalises the single registered OR-reduce of a wide bus into several features:
- CHANNELS independent buses of WIDTH bits.
- Per-transaction op select: OR, AND, XOR or NOR.
- A FANIN-ary registered reduction tree.
- valid/ready flow control.
- A per-channel sticky accumulator of results.

It sits between a producer of wide status buses and consumers of single-bit flags. It is also a test vehicle for constant propagation and buffering passes.

Parameters:
WIDTH, 16, bits per channel; must be >= 2.
CHANNELS, 2, number of independent channels; must be >= 1.
FANIN, 4, inputs reduced per tree node per stage; must be >= 2.
Derived: LAT = max(1, ceil(log_FANIN(WIDTH))) pipeline stages. WIDTH=16, FANIN=4 gives LAT=2.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
in_op  in  2  00=OR, 01=AND, 10=XOR, 11=NOR; applies to all channels of the beat
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_reduced  out  CHANNELS  per-channel reduction result
out_op  out  2  op of the beat being presented
out_any  out  1  OR of out_reduced across channels
acc_clear  in  1  synchronous clear of sticky accumulator
out_sticky  out  CHANNELS  OR of all out_reduced values accepted since last clear/reset

Behaviour:
- Reset (reset_n low, asynchronous):
  - all stage valid bits, out_valid, out_reduced, out_op, out_any and out_sticky go to 0;
  - stage data registers go to 0.
  - in_ready = 1 from the first cycle after reset deassertion.
- Pipeline advance: advance = !out_valid || out_ready.
  - The whole pipeline shifts when advance is 1 and holds all registers otherwise.
  - in_ready = advance (combinational).
  - A beat is accepted when in_valid && in_ready.
  - Bubbles advance like data, with valid=0.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+LAT-1 (LAT registered stages, last stage drives the outputs), given no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_reduced, out_op and out_any hold stable, and no input is accepted.
- Tree:
  - Each stage groups its operand vector into ceil(n/FANIN) nodes.
  - Each node reduces up to FANIN bits with the base op: OR for OR/NOR, AND for AND, XOR for XOR.
  - A short final group is padded with the identity element: 0 for OR/XOR/NOR, 1 for AND.
  - The op code travels with its beat through every stage.
  - NOR inverts the final single bit at the last stage only.
- If WIDTH <= FANIN, LAT = 1 and the single stage reduces fully.
- out_any is registered with out_reduced; it is not recomputed combinationally from stalled data.
- Sticky accumulator, per channel, on each edge:
  - acc_clear && handshake: out_sticky <= out_reduced (clear then include the current beat).
  - acc_clear only: out_sticky <= 0.
  - handshake only: out_sticky <= out_sticky | out_reduced.
  - else: hold.
  - handshake = out_valid && out_ready.
- Reset mid-operation discards all in-flight beats; none is presented after reset release.
- in_op and in_data are sampled only on acceptance; changes while in_ready=0 have no effect.

Test Plan:
(Defaults: WIDTH=16, CHANNELS=2, FANIN=4, LAT=2.)
- Basic ops, out_ready=1:
  - in_data=0x0000_0001, op=OR -> two cycles later out_reduced=2'b01, out_any=1.
  - same data, op=NOR -> out_reduced=2'b10.
  - in_data=0xFFFF_FFFE, op=AND -> 2'b10.
  - in_data=0x0007_0003, op=XOR -> 2'b10.
- Streaming: 8 back-to-back beats, ops cycling OR/AND/XOR/NOR -> 8 results on consecutive cycles, in order, each out_op matching its beat, in_ready constantly 1.
- Backpressure:
  - out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, outputs frozen, no beat lost or duplicated.
  - release -> remaining beats drain in order.
- Padding: WIDTH=10, FANIN=4 (LAT=2).
  - in_data=10'h3FF, op=AND -> 1.
  - in_data=10'h000, op=OR -> 0.
  - This proves identity padding for both ops.
- Sticky accumulator:
  - results 2'b01 then 2'b10 accepted -> out_sticky=2'b11.
  - acc_clear together with accepting 2'b01 -> out_sticky=2'b01 on the next cycle.
  - acc_clear alone -> 2'b00.
- Async reset: assert reset_n=0 mid-stream, between clock edges -> all outputs 0 immediately; after release, no stale out_valid, and in_ready=1.
